// File: rtl/rx_frame_pkg.sv
// Shared types and constants for the receive-side frame controller.
package rx_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    PAYLOAD,
    CHK,
    DRAIN,
    RESYNC
  } state_t;

  localparam logic [2:0] ERR_LEN  = 3'd0;
  localparam logic [2:0] ERR_CHK  = 3'd1;
  localparam logic [2:0] ERR_TMO  = 3'd2;
  localparam logic [2:0] ERR_LINE = 3'd3;
  localparam logic [2:0] ERR_OVR  = 3'd4;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;
  // Receiver substitutes this byte when a stop bit is missing.
  localparam logic [7:0] LINE_ERR_BYTE = 8'hFF;

endpackage

// File: rtl/rx_frame_if.sv
// Receiver-side byte input, downstream payload stream and error report of rx_frame_ctrl.
interface rx_frame_if;
  logic [7:0] rx_word;
  logic       rx_ready;
  logic       rx_rst;
  logic [7:0] frm_data;
  logic       frm_valid;
  logic       frm_ready;
  logic       frm_last;
  logic [7:0] frm_len;
  logic       err_valid;
  logic [2:0] err_code;

  modport master (
    input  rx_word, rx_ready, frm_ready,
    output rx_rst, frm_data, frm_valid, frm_last, frm_len, err_valid, err_code
  );

  modport slave (
    output rx_word, rx_ready, frm_ready,
    input  rx_rst, frm_data, frm_valid, frm_last, frm_len, err_valid, err_code
  );
endinterface

// File: rtl/rx_frame_buf.sv
// Payload buffer: one synchronous write port, one combinational read port.
module rx_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // NOTE: storage has no reset; write/read indices restart per frame, so stale bytes are never read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rx_frame_ctrl.sv
// Frame parser behind the serial byte receiver: SOF, LEN, payload, CHK; releases
// checked payloads over a valid/ready stream and resynchronises the receiver on errors.
module rx_frame_ctrl
  import rx_frame_pkg::*;
#(
  parameter logic [7:0] SOF     = SOF_DEFAULT,
  parameter int         MAX_LEN = 16,
  parameter int         TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  rx_frame_if.master bus
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t         state_q, state_d;
  logic           ready_q;
  logic [7:0]     chk_q, len_q, frm_len_q;
  logic [AW-1:0]  idx_q, rd_q;
  logic [TW-1:0]  tmo_q;
  logic           err_valid_q;
  logic [2:0]     err_code_q;
  logic           err_set;
  logic [2:0]     err_d;
  logic [7:0]     rx, rd_data;
  logic           stb, line_err, len_bad, in_frame, tmo_hit;
  logic           last_wr, last_rd, xfer, wr_en;

  assign rx       = bus.rx_word;
  assign stb      = bus.rx_ready & ~ready_q;
  assign line_err = (rx == LINE_ERR_BYTE);
  assign len_bad  = (rx == 8'd0) || (rx > 8'(MAX_LEN));
  assign in_frame = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHK);
  // A strobe on the expiry cycle takes priority over the timeout.
  assign tmo_hit  = in_frame && !stb && (tmo_q == TW'(TIMEOUT - 1));
  assign last_wr  = (8'(idx_q) == len_q - 8'd1);
  assign last_rd  = (8'(rd_q) == len_q - 8'd1);
  assign xfer     = (state_q == DRAIN) && bus.frm_ready;
  assign wr_en    = (state_q == PAYLOAD) && stb && !line_err;

  rx_frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (idx_q),
    .wdata (rx),
    .raddr (rd_q),
    .rdata (rd_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    err_d   = ERR_LEN;
    case (state_q)
      IDLE: if (stb && rx == SOF) state_d = LEN;
      LEN: begin
        if (stb) begin
          if (line_err)     begin state_d = RESYNC; err_set = 1'b1; err_d = ERR_LINE; end
          else if (len_bad) begin state_d = RESYNC; err_set = 1'b1; err_d = ERR_LEN;  end
          else                    state_d = PAYLOAD;
        end else if (tmo_hit) begin
          state_d = RESYNC; err_set = 1'b1; err_d = ERR_TMO;
        end
      end
      PAYLOAD: begin
        if (stb) begin
          if (line_err)     begin state_d = RESYNC; err_set = 1'b1; err_d = ERR_LINE; end
          else if (last_wr)       state_d = CHK;
        end else if (tmo_hit) begin
          state_d = RESYNC; err_set = 1'b1; err_d = ERR_TMO;
        end
      end
      CHK: begin
        if (stb) begin
          if (rx == chk_q) state_d = DRAIN;
          else begin state_d = RESYNC; err_set = 1'b1; err_d = ERR_CHK; end
        end else if (tmo_hit) begin
          state_d = RESYNC; err_set = 1'b1; err_d = ERR_TMO;
        end
      end
      DRAIN: begin
        if (xfer && last_rd) state_d = IDLE;
        if (stb) begin err_set = 1'b1; err_d = ERR_OVR; end
      end
      RESYNC:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q     <= 1'b1;
      chk_q       <= '0;
      len_q       <= '0;
      frm_len_q   <= '0;
      idx_q       <= '0;
      rd_q        <= '0;
      tmo_q       <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      ready_q     <= bus.rx_ready;
      err_valid_q <= err_set;
      if (err_set) err_code_q <= err_d;
      if (stb || !in_frame || state_d != state_q) tmo_q <= '0;
      else                                        tmo_q <= tmo_q + TW'(1);
      case (state_q)
        LEN: if (stb && !line_err && !len_bad) begin
          len_q <= rx;
          chk_q <= rx;
          idx_q <= '0;
        end
        PAYLOAD: if (stb && !line_err) begin
          chk_q <= chk_q ^ rx;
          idx_q <= idx_q + AW'(1);
        end
        CHK: if (stb && rx == chk_q) begin
          frm_len_q <= len_q;
          rd_q      <= '0;
        end
        DRAIN: if (xfer) rd_q <= rd_q + AW'(1);
        default: ;
      endcase
    end
  end

  logic       frm_valid_c, frm_last_c, rx_rst_c;
  logic [7:0] frm_data_c;

  always_comb begin
    frm_valid_c = (state_q == DRAIN);
    frm_last_c  = (state_q == DRAIN) && last_rd;
    frm_data_c  = (state_q == DRAIN) ? rd_data : 8'd0;
    rx_rst_c    = (state_q == RESYNC);
  end

  assign bus.frm_valid = frm_valid_c;
  assign bus.frm_last  = frm_last_c;
  assign bus.frm_data  = frm_data_c;
  assign bus.frm_len   = frm_len_q;
  assign bus.rx_rst    = rx_rst_c;
  assign bus.err_valid = err_valid_q;
  assign bus.err_code  = err_code_q;

endmodule

// File: doc/rx_frame_ctrl.md
Name: rx_frame_ctrl

Overview:
Frame-level controller that sits directly behind the serial byte receiver. It turns the receiver's level-type ready/word pair into byte strobes and parses frames of the form SOF, LEN, payload, CHK. Each payload is buffered and released downstream over a valid/ready stream only after its checksum passes. On any protocol error it resynchronises the receiver through a dedicated reset pulse.

Parameters:
SOF, 8'hA5, start-of-frame byte.
MAX_LEN, 16, maximum payload length in bytes (1..255).
TIMEOUT, 64, maximum clk cycles allowed between byte strobes inside a frame.

Ports:
clk  in  1  clock.
rst  in  1  reset, synchronous, active-high.
rx_word  in  8  byte from receiver.
rx_ready  in  1  receiver ready level; a 0->1 transition marks a new byte.
rx_rst  out  1  one-cycle reset pulse to receiver (top level ORs it with rst).
frm_data  out  8  payload byte.
frm_valid  out  1  frm_data valid.
frm_ready  in  1  consumer accepts the byte.
frm_last  out  1  high with the final payload byte.
frm_len  out  8  length of the frame being drained.
err_valid  out  1  one-cycle error pulse.
err_code  out  3  0=LEN, 1=CHK, 2=TMO, 3=LINE, 4=OVR; valid with err_valid.

Behaviour:
- Reset: state IDLE; rx_rst=0, frm_valid=0, frm_last=0, frm_data=0, frm_len=0, err_valid=0, err_code=0; ready_q=1, checksum, index and timeout counter all 0.
- Byte strobe: stb = rx_ready & ~ready_q, where ready_q is rx_ready registered. All actions below occur at the edge where stb is high.
- rx_word==8'hFF is a line error (receiver missing-stop marker) in LEN and PAYLOAD. In CHK it is compared as an ordinary value.
- IDLE: stb with byte==SOF goes to LEN. Any other byte, including 8'hFF, is dropped silently.
- LEN:
  - byte 0 or byte > MAX_LEN: error LEN, go to RESYNC.
  - otherwise latch len; chk=byte; idx=0; go to PAYLOAD.
- PAYLOAD: buf[idx]=byte; chk^=byte; idx++. When idx==len-1, go to CHK.
- CHK:
  - byte==chk: go to DRAIN with rd=0, frm_len=len.
  - otherwise: error CHK, go to RESYNC.
- Timeout:
  - In LEN, PAYLOAD and CHK, the counter clears on each stb and on state entry, and increments otherwise.
  - Reaching TIMEOUT gives error TMO and RESYNC.
  - stb in the same cycle as the timeout wins: the byte is processed and the counter clears.
- RESYNC (1 cycle): rx_rst=1, err_valid=1 with the registered code, buffer contents discarded, then IDLE. err_valid and rx_rst rise the cycle after the offending edge.
- DRAIN:
  - frm_valid=1, frm_data=buf[rd], frm_last=(rd==len-1). frm_valid rises the cycle after the CHK strobe.
  - A transfer occurs when frm_valid & frm_ready; rd then increments.
  - Outputs hold stable while frm_ready=0.
  - The transfer with frm_last clears frm_valid and returns to IDLE.
  - Any stb during DRAIN: byte dropped, err_valid with OVR; drain continues, no rx_rst.
- Checksum: 8-bit XOR of LEN and all payload bytes.
- rst mid-operation: immediate return to reset values. A partially buffered frame is never emitted.

Decomposition:
- Package rx_frame_pkg:
  - state enum IDLE/LEN/PAYLOAD/CHK/DRAIN/RESYNC.
  - err_code constants ERR_LEN/ERR_CHK/ERR_TMO/ERR_LINE/ERR_OVR.
  - default SOF constant.
- Sub-module rx_frame_buf: MAX_LEN x 8 register file with one synchronous write port and one combinational read port, indexed by idx/rd.

Test Plan:
- Good frame: send A5 03 11 22 33 03 with frm_ready=1 -> frm_data 11,22,33 on consecutive cycles; frm_last only with 33; frm_len=3; err_valid never high.
- Bad check: send A5 03 11 22 33 04 -> one err_valid pulse, code 1; one rx_rst pulse; frm_valid stays 0; a following good frame drains correctly.
- Length and line errors: LEN 00 -> code 0. LEN 11h with MAX_LEN=16 -> code 0. A5 02 FF -> code 3. Each gives exactly one rx_rst pulse.
- Timeout: send A5 02 AA, then no rx_ready edge -> err_valid code 2 exactly TIMEOUT cycles after the AA strobe. Repeat with a byte arriving on the timeout cycle -> no error.
- Backpressure and overrun: good 2-byte frame; hold frm_ready=0 for 5 cycles and inject a byte during DRAIN -> frm_data stable while stalled; one OVR (code 4) pulse; both bytes delivered; frm_last on the second.
- Resilience: 00 FF 12 before SOF -> ignored. rst asserted mid-PAYLOAD -> all outputs at reset values next cycle, and a subsequent good frame is delivered intact.
